// File: rtl/jk_flipflop_pkg.sv
`default_nettype none
// ============================================================================
// Module  : jk_flipflop_pkg
// Brief   : JK command encoding and next-state function shared by RTL and bench
// Revision: 1.0
// ============================================================================
package jk_flipflop_pkg;

  typedef enum logic [1:0] {
    JK_HOLD = 2'b00,
    JK_CLR  = 2'b01,
    JK_SET  = 2'b10,
    JK_TGL  = 2'b11
  } jk_cmd_e;

  // Characteristic equation rather than a case so X on J or K propagates to Q.
  function automatic logic next_q(input logic [1:0] cmd, input logic q);
    return (cmd[1] & ~q) | (~cmd[0] & q);
  endfunction

endpackage
`default_nettype wire

// File: rtl/jk_flipflop_jk_cell.sv
`default_nettype none
// ============================================================================
// Module  : jk_cell
// Brief   : One JK bit: async active-low reset flop plus next-state logic
// Revision: 1.0
// ============================================================================
module jk_cell
  import jk_flipflop_pkg::*;
#(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic j_i,
  input  logic k_i,
  output logic q_o
);

  logic q_q;
  logic q_d;

  always_comb begin
    q_d = next_q({j_i, k_i}, q_q);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q_q <= RESET_VAL;
    end else begin
      q_q <= q_d;
    end
  end

  assign q_o = q_q;

endmodule
`default_nettype wire

// File: rtl/jk_flipflop.sv
`default_nettype none
// ============================================================================
// Module  : jk_flipflop
// Brief   : Bank of WIDTH independent JK flip-flops with complement output
// Revision: 1.0
// ============================================================================
module jk_flipflop
  import jk_flipflop_pkg::*;
#(
  parameter int               WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] J,
  input  logic [WIDTH-1:0] K,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] Q_n
);

  generate
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      jk_cell #(
        .RESET_VAL (RESET_VAL[i])
      ) u_cell (
        .clk   (clk),
        .reset (reset),
        .j_i   (J[i]),
        .k_i   (K[i]),
        .q_o   (Q[i])
      );
    end
  endgenerate

  assign Q_n = ~Q;

endmodule
`default_nettype wire

// File: tb/tb_jk_flipflop.sv
`default_nettype none
// ============================================================================
// Module  : tb_jk_flipflop
// Brief   : Directed and randomized checks of 1-bit and 4-bit jk_flipflop
// Revision: 1.0
// ============================================================================
module tb_jk_flipflop;
  import jk_flipflop_pkg::*;

  logic       clk = 1'b0;
  logic       rst1, j1, k1;
  logic       q1, qn1;
  logic       rst4;
  logic [3:0] j4, k4, q4, qn4;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  jk_flipflop #(.WIDTH(1), .RESET_VAL(1'b0)) u_dut1 (
    .clk(clk), .reset(rst1), .J(j1), .K(k1), .Q(q1), .Q_n(qn1)
  );

  jk_flipflop #(.WIDTH(4), .RESET_VAL(4'b1010)) u_dut4 (
    .clk(clk), .reset(rst4), .J(j4), .K(k4), .Q(q4), .Q_n(qn4)
  );

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  initial begin
    logic [1:0] cmds [6];
    logic       exp1 [6];
    logic [3:0] model, model_nx;
    logic       rnd_rst;

    cmds = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b01, 2'b11};
    exp1 = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

    // Reset held with toggle requested on the 1-bit instance
    rst1 = 1'b0; j1 = 1'b1; k1 = 1'b1;
    rst4 = 1'b0; j4 = 4'b0000; k4 = 4'b0000;
    repeat (3) begin
      @(negedge clk);
      chk("rst_q", {3'b0, q1}, 4'b0000);
      chk("rst_qn", {3'b0, qn1}, 4'b0001);
    end
    chk("rst4_q", q4, 4'b1010);
    chk("rst4_qn", qn4, 4'b0101);

    // Command sweep, one edge per command
    rst1 = 1'b1;
    for (int i = 0; i < 6; i++) begin
      {j1, k1} = cmds[i];
      @(negedge clk);
      chk($sformatf("sweep%0d", i), {3'b0, q1}, {3'b0, exp1[i]});
      chk($sformatf("sweep%0d_qn", i), {3'b0, qn1}, {3'b0, ~exp1[i]});
    end

    // Asynchronous reset between edges, then across an edge with J=1
    j1 = 1'b1; k1 = 1'b0;
    #2 rst1 = 1'b0;
    #1 chk("async_rst", {3'b0, q1}, 4'b0000);
    chk("async_rst_qn", {3'b0, qn1}, 4'b0001);
    @(negedge clk);
    chk("rst_over_edge", {3'b0, q1}, 4'b0000);
    rst1 = 1'b1;
    @(negedge clk);
    chk("set_after_rel", {3'b0, q1}, 4'b0001);

    // Clear, then sustained toggle for four edges
    j1 = 1'b0; k1 = 1'b1;
    @(negedge clk);
    chk("clr_before_tgl", {3'b0, q1}, 4'b0000);
    j1 = 1'b1; k1 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("tgl%0d", i), {3'b0, q1}, {3'b0, ~i[0]});
      chk($sformatf("tgl%0d_qn", i), {3'b0, qn1}, {3'b0, i[0]});
    end

    // From 1010: bit3 CLR->0, bit2 TGL->1, bit1 HOLD->1, bit0 SET->1
    rst4 = 1'b1; j4 = 4'b0101; k4 = 4'b1100;
    @(negedge clk);
    chk("multi_bit", q4, 4'b0111);
    chk("multi_bit_qn", qn4, 4'b1000);

    // X on one J bit corrupts only that bit
    j4 = 4'bx000; k4 = 4'b0000;
    @(negedge clk);
    chk("x_prop", q4, 4'bx111);

    rst4 = 1'b0; j4 = 4'b0000;
    #1 chk("rst4_again", q4, 4'b1010);
    model = 4'b1010;

    // Randomized run against the package model with occasional reset pulses
    for (int c = 0; c < 1000; c++) begin
      j4 = 4'($urandom);
      k4 = 4'($urandom);
      rnd_rst = ($urandom_range(0, 15) == 0);
      rst4 = ~rnd_rst;
      for (int b = 0; b < 4; b++) begin
        model_nx[b] = next_q({j4[b], k4[b]}, model[b]);
      end
      if (rnd_rst) model_nx = 4'b1010;
      @(negedge clk);
      model = model_nx;
      chk($sformatf("rand%0d", c), q4, model);
      chk($sformatf("rand%0d_qn", c), qn4, ~model);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
